// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU RAM strobes. It holds the word-addressed
//   program/data RAM and serves reads and writes addressed by MAR to and from
//   the MDR. User-mode writes to the low vector region are blocked and pulse
//   cpu_fault_o. A streaming loader port fills the RAM from address 0 upward
//   while the CPU is held off; this is used for program boot.
//
// Ports
//   clk, reset    system clock; asynchronous active-high reset
//   cpu_addr_i    word address from MAR
//   cpu_wdata_i   write data from MDR
//   cpu_rd_i      read strobe (RAM_enable_read)
//   cpu_wr_i      write strobe (RAM_enable_write)
//   cpu_priv_i    PSW privileged bit
//   cpu_rdata_o   registered read data, valid the cycle after the strobe
//   cpu_fault_o   one-cycle pulse when a protected write is blocked
//   ld_mode_i     request loader mode
//   ld_valid_i    loader word valid
//   ld_data_i     loader word
//   ld_ready_o    loader can accept a word
//   ld_count_o    number of words written since entering LOAD
//   busy_o        loader owns the RAM; CPU accesses are ignored
//
// State | meaning
//   RUN       | CPU owns the RAM
//   LOAD      | loader streams words into sequential addresses
//   LOAD_FULL | every address has been loaded; further words are refused
module mem_responder #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PROT_TOP = 'h0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_priv_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_fault_o,
    input  logic              ld_mode_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {RUN, LOAD, LOAD_FULL} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_fault_q;
    logic              ld_ready_q;
    logic              busy_q;
    logic [ADDR_W:0]   ld_count_q;

    // RAM has no reset: words loaded before a reset must survive it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              cpu_blocked;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign cpu_blocked = ~cpu_priv_i & (cpu_addr_i <= PROT_TOP);

    // Single write port, shared by loader (LOAD) and CPU (RUN).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr_i;
        mem_wdata = cpu_wdata_i;
        if (state_q == LOAD && ld_valid_i) begin
            mem_we    = 1'b1;
            mem_waddr = ld_count_q[ADDR_W-1:0];
            mem_wdata = ld_data_i;
        end else if (state_q == RUN && cpu_wr_i && !cpu_blocked) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cpu_rdata_q <= '0;
            cpu_fault_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            ld_count_q  <= '0;
        end else begin
            cpu_fault_q <= 1'b0;
            case (state_q)
                RUN: begin
                    // The read samples the old word, so a simultaneous write
                    // to the same address is read-before-write.
                    if (cpu_rd_i) begin
                        cpu_rdata_q <= mem_q[cpu_addr_i];
                    end
                    if (cpu_wr_i && cpu_blocked) begin
                        cpu_fault_q <= 1'b1;
                    end
                    if (ld_mode_i) begin
                        state_q    <= LOAD;
                        ld_count_q <= '0;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid_i) begin
                        ld_count_q <= ld_count_q + 1'b1;
                    end
                    if (!ld_mode_i) begin
                        state_q    <= RUN;
                        ld_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (ld_valid_i && (&ld_count_q[ADDR_W-1:0])) begin
                        state_q    <= LOAD_FULL;
                        ld_ready_q <= 1'b0;
                    end
                end
                LOAD_FULL: begin
                    if (!ld_mode_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    ld_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_fault_o = cpu_fault_q;
    assign ld_ready_o  = ld_ready_q;
    assign busy_o      = busy_q;
    assign ld_count_o  = ld_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the responder that is stepped once per clock edge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cpu_addr_i = '0;
    logic [15:0] cpu_wdata_i = '0;
    logic        cpu_rd_i = 1'b0;
    logic        cpu_wr_i = 1'b0;
    logic        cpu_priv_i = 1'b0;
    logic [15:0] cpu_rdata_o;
    logic        cpu_fault_o;
    logic        ld_mode_i = 1'b0;
    logic        ld_valid_i = 1'b0;
    logic [15:0] ld_data_i = '0;
    logic        ld_ready_o;
    logic [8:0]  ld_count_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rd_i    (cpu_rd_i),
        .cpu_wr_i    (cpu_wr_i),
        .cpu_priv_i  (cpu_priv_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_fault_o (cpu_fault_o),
        .ld_mode_i   (ld_mode_i),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ld_ready_o),
        .ld_count_o  (ld_count_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = CPU mode, 1 = loading, 2 = loader full.
    int          m_mode;
    int          m_count;
    logic [15:0] m_mem [256];
    bit          m_known [256];
    logic [15:0] m_rdata;
    bit          m_rd_known;
    bit          m_fault;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_count    = 0;
        m_rdata    = 16'h0;
        m_rd_known = 1'b1;
        m_fault    = 1'b0;
    endtask

    task automatic model_step();
        m_fault = 1'b0;
        if (m_mode == 0) begin
            if (cpu_rd_i) begin
                m_rdata    = m_mem[cpu_addr_i];
                m_rd_known = m_known[cpu_addr_i];
            end
            if (cpu_wr_i) begin
                if (!cpu_priv_i && cpu_addr_i <= 8'h0F) begin
                    m_fault = 1'b1;
                end else begin
                    m_mem[cpu_addr_i]   = cpu_wdata_i;
                    m_known[cpu_addr_i] = 1'b1;
                end
            end
            if (ld_mode_i) begin
                m_mode  = 1;
                m_count = 0;
            end
        end else begin
            if (m_mode == 1 && ld_valid_i) begin
                m_mem[m_count]   = ld_data_i;
                m_known[m_count] = 1'b1;
                m_count++;
            end
            if (!ld_mode_i) m_mode = 0;
            else if (m_count == 256) m_mode = 2;
        end
    endtask

    task automatic check_outputs();
        if (m_rd_known) chk("rdata", cpu_rdata_o, m_rdata);
        chk("fault", cpu_fault_o, m_fault);
        chk("ld_ready", ld_ready_o, m_mode == 1);
        chk("busy", busy_o, m_mode != 0);
        chk("ld_count", ld_count_o, m_count);
    endtask

    // One clock edge: model follows the edge, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cpu_rd_i   = 1'b0;
        cpu_wr_i   = 1'b0;
        ld_valid_i = 1'b0;
    endtask

    task automatic cpu_op(input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d);
        idle();
        cpu_rd_i    = rd;
        cpu_wr_i    = wr;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        cycle();
    endtask

    task automatic ld_word(input logic [15:0] d);
        idle();
        ld_valid_i = 1'b1;
        ld_data_i  = d;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        model_reset();
        #2;
        check_outputs();
        #10 reset = 1'b0;

        // 1: boot load of three words, then read them back
        ld_mode_i = 1'b1;
        cycle();
        ld_word(16'h1111); chk("t1_cnt1", ld_count_o, 1);
        ld_word(16'h2222); chk("t1_cnt2", ld_count_o, 2);
        ld_word(16'h3333); chk("t1_cnt3", ld_count_o, 3);
        idle();
        ld_mode_i = 1'b0;
        cycle();
        chk("t1_busy", busy_o, 0);
        cpu_op(1, 0, 8'h00, 0); chk("t1_rd0", cpu_rdata_o, 16'h1111);
        cpu_op(1, 0, 8'h01, 0); chk("t1_rd1", cpu_rdata_o, 16'h2222);
        cpu_op(1, 0, 8'h02, 0); chk("t1_rd2", cpu_rdata_o, 16'h3333);

        // 2: privileged write into the protected region
        cpu_priv_i = 1'b1;
        cpu_op(0, 1, 8'h05, 16'hABCD); chk("t2_fault", cpu_fault_o, 0);
        cpu_op(1, 0, 8'h05, 0);        chk("t2_rd", cpu_rdata_o, 16'hABCD);

        // 3: user write blocked at the top of the region, allowed just above
        cpu_op(0, 1, 8'h0F, 16'h5A5A);
        cpu_priv_i = 1'b0;
        cpu_op(0, 1, 8'h0F, 16'hBEEF); chk("t3_fault_hi", cpu_fault_o, 1);
        cpu_op(1, 0, 8'h0F, 0);        chk("t3_fault_lo", cpu_fault_o, 0);
        chk("t3_rd_prot", cpu_rdata_o, 16'h5A5A);
        cpu_op(0, 1, 8'h10, 16'hBEEF); chk("t3_fault_10", cpu_fault_o, 0);
        cpu_op(1, 0, 8'h10, 0);        chk("t3_rd_10", cpu_rdata_o, 16'hBEEF);

        // 4: simultaneous read and write is read-before-write
        cpu_op(0, 1, 8'h20, 16'h0001);
        cpu_op(1, 1, 8'h20, 16'h0002); chk("t4_old", cpu_rdata_o, 16'h0001);
        cpu_op(1, 0, 8'h20, 0);        chk("t4_new", cpu_rdata_o, 16'h0002);

        // 5: fill the whole RAM, extra word refused
        idle();
        ld_mode_i = 1'b1;
        cycle();
        for (int i = 0; i < 256; i++) ld_word(16'(i * 3 + 7));
        chk("t5_cnt", ld_count_o, 256);
        chk("t5_ready", ld_ready_o, 0);
        chk("t5_busy", busy_o, 1);
        ld_word(16'hFFFF);
        chk("t5_cnt_hold", ld_count_o, 256);
        idle();
        ld_mode_i = 1'b0;
        cycle();
        chk("t5_busy_off", busy_o, 0);
        cpu_op(1, 0, 8'h00, 0); chk("t5_mem0", cpu_rdata_o, 16'h0007);

        // 6: CPU write ignored while loading, then reset mid-load
        idle();
        ld_mode_i = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) ld_word(16'(16'h0100 + i));
        chk("t6_cnt5", ld_count_o, 5);
        cpu_priv_i = 1'b1;
        cpu_op(0, 1, 8'h30, 16'hDEAD); chk("t6_nofault", cpu_fault_o, 0);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_ready", ld_ready_o, 0);
        chk("t6_rst_cnt", ld_count_o, 0);
        model_reset();
        ld_mode_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_op(1, 0, 8'(i), 0);
            chk("t6_keep", cpu_rdata_o, 32'(16'h0100 + i));
        end
        cpu_op(1, 0, 8'h30, 0); chk("t6_no_wr", cpu_rdata_o, 16'h0097);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) ld_mode_i = ~ld_mode_i;
            ld_valid_i  = 1'($urandom_range(0, 1));
            ld_data_i   = 16'($urandom);
            cpu_rd_i    = 1'($urandom_range(0, 1));
            cpu_wr_i    = 1'($urandom_range(0, 1));
            cpu_priv_i  = 1'($urandom_range(0, 1));
            cpu_addr_i  = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            cpu_wdata_i = 16'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
